// File: rtl/nametable_scroll_ram_pkg.sv
// Shared definitions for the scrolled name table RAM: default geometry,
// derived sizes, fill FSM encoding and small data-shaping helpers.
package nametable_scroll_ram_pkg;

    localparam int NT_WIDTH_DEF   = 32;
    localparam int NT_HEIGHT_DEF  = 30;
    localparam int NUM_PAGES_DEF  = 2;
    localparam int DEPTH_DEF      = NUM_PAGES_DEF * NT_WIDTH_DEF * NT_HEIGHT_DEF / 4;
    localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);
    localparam int XW_DEF         = $clog2(NT_WIDTH_DEF * NUM_PAGES_DEF);
    localparam int YW_DEF         = $clog2(NT_HEIGHT_DEF);

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

    // CPU byte enables arrive lane-reversed: wea[3] owns bits [7:0].
    function automatic logic [3:0] cpu_lane_en(input logic [3:0] wea);
        return {wea[0], wea[1], wea[2], wea[3]};
    endfunction

    // A fill writes the same tile index into all four bytes of a word.
    function automatic logic [31:0] fill_word(input logic [7:0] value);
        return {4{value}};
    endfunction

endpackage

// File: rtl/nametable_scroll_ram_addr.sv
// Scroll wrap-around and linear tile index for the fetch port. Pure
// combinational; the caller registers the result. Inputs must be in range
// because each axis wraps with a single conditional subtract.
module nametable_scroll_addr
    import nametable_scroll_ram_pkg::*;
#(
    parameter int NT_WIDTH   = NT_WIDTH_DEF,
    parameter int NT_HEIGHT  = NT_HEIGHT_DEF,
    parameter int NUM_PAGES  = NUM_PAGES_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int XW         = XW_DEF,
    parameter int YW         = YW_DEF
) (
    input  logic [XW-1:0]         fetch_x_i,
    input  logic [YW-1:0]         fetch_y_i,
    input  logic [XW-1:0]         scroll_x_i,
    input  logic [YW-1:0]         scroll_y_i,
    output logic [ADDR_WIDTH-1:0] word_addr_o,
    output logic [1:0]            byte_sel_o
);

    localparam int W_TOT = NT_WIDTH * NUM_PAGES;
    localparam int TW    = ADDR_WIDTH + 2;

    logic [XW:0]   sx_s;
    logic [YW:0]   sy_s;
    logic [XW-1:0] ex_s;
    logic [YW-1:0] ey_s;
    logic [XW-1:0] col_s;
    logic [2:0]    page_s;
    logic [TW-1:0] t_s;

    // Wrap both axes, split x into page and column, then form the tile index.
    always_comb begin
        sx_s = {1'b0, fetch_x_i} + {1'b0, scroll_x_i};
        sy_s = {1'b0, fetch_y_i} + {1'b0, scroll_y_i};
        if (sx_s >= (XW+1)'(W_TOT)) begin
            ex_s = XW'(sx_s - (XW+1)'(W_TOT));
        end else begin
            ex_s = sx_s[XW-1:0];
        end
        if (sy_s >= (YW+1)'(NT_HEIGHT)) begin
            ey_s = YW'(sy_s - (YW+1)'(NT_HEIGHT));
        end else begin
            ey_s = sy_s[YW-1:0];
        end
        // At most four pages: a few compares instead of a divider.
        page_s = 3'd0;
        for (int k = 1; k < NUM_PAGES; k++) begin
            if (ex_s >= XW'(k * NT_WIDTH)) begin
                page_s = 3'(k);
            end else begin
                page_s = page_s;
            end
        end
        col_s = ex_s - XW'(32'(page_s) * NT_WIDTH);
        t_s   = TW'(32'(page_s) * NT_WIDTH * NT_HEIGHT)
              + TW'(32'(ey_s) * NT_WIDTH)
              + TW'(col_s);
        word_addr_o = t_s[TW-1:2];
        byte_sel_o  = t_s[1:0];
    end

endmodule

// File: rtl/nametable_scroll_ram.sv
// Multi-page PPU name table: CPU byte-write/word-read port, whole-table fill
// engine and a two-cycle scrolled tile fetch port. All reads are read-first.
module nametable_scroll_ram
    import nametable_scroll_ram_pkg::*;
#(
    parameter int NT_WIDTH   = NT_WIDTH_DEF,
    parameter int NT_HEIGHT  = NT_HEIGHT_DEF,
    parameter int NUM_PAGES  = NUM_PAGES_DEF,
    parameter int DEPTH      = NUM_PAGES * NT_WIDTH * NT_HEIGHT / 4,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int XW         = XW_DEF,
    parameter int YW         = YW_DEF,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [3:0]            cpu_wea,
    input  logic [ADDR_WIDTH-1:0] cpu_addra,
    input  logic [31:0]           cpu_dina,
    input  logic [ADDR_WIDTH-1:0] cpu_addrb,
    output logic [31:0]           cpu_doutb,
    input  logic                  fill_start,
    input  logic [7:0]            fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    input  logic                  fetch_req,
    input  logic [XW-1:0]         fetch_x,
    input  logic [YW-1:0]         fetch_y,
    input  logic [XW-1:0]         scroll_x,
    input  logic [YW-1:0]         scroll_y,
    output logic                  fetch_valid,
    output logic [7:0]            fetch_tile
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           cpu_doutb_q;
    fill_state_e           state_q;
    logic [ADDR_WIDTH-1:0] fill_cnt_q;
    logic [7:0]            fill_val_q;
    logic                  fill_busy_q;
    logic                  fill_done_q;
    logic                  f0_valid_q;
    logic [ADDR_WIDTH-1:0] f0_addr_q;
    logic [1:0]            f0_sel_q;
    logic                  fetch_valid_q;
    logic [7:0]            fetch_tile_q;

    logic                  cpu_wr_s;
    logic [3:0]            wr_be_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [31:0]           wr_data_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic [1:0]            byte_sel_s;

    assign cpu_wr_s = (cpu_wea != 4'b0000);

    // Single write port: CPU wins, the fill engine only writes when the CPU is silent.
    always_comb begin
        wr_be_s   = 4'b0000;
        wr_addr_s = cpu_addra;
        wr_data_s = cpu_dina;
        if (cpu_wr_s) begin
            wr_be_s = cpu_lane_en(cpu_wea);
        end else if (state_q == FILL_RUN) begin
            wr_be_s   = 4'b1111;
            wr_addr_s = fill_cnt_q;
            wr_data_s = fill_word(fill_val_q);
        end else begin
            wr_be_s = 4'b0000;
        end
    end

    // Byte-enable RAM write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be_s[b]) begin
                mem_q[wr_addr_s][8*b +: 8] <= wr_data_s[8*b +: 8];
            end
        end
    end

    // CPU read port, one cycle latency, sees pre-write data on a collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_doutb_q <= 32'h0000_0000;
        end else begin
            cpu_doutb_q <= mem_q[cpu_addrb];
        end
    end

    // Fill FSM: sweep every word once, stall while the CPU owns the write port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FILL_IDLE;
            fill_cnt_q  <= {ADDR_WIDTH{1'b0}};
            fill_val_q  <= 8'h00;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            case (state_q)
                FILL_IDLE: begin
                    fill_done_q <= 1'b0;
                    if (fill_start) begin
                        state_q     <= FILL_RUN;
                        fill_cnt_q  <= {ADDR_WIDTH{1'b0}};
                        fill_val_q  <= fill_value;
                        fill_busy_q <= 1'b1;
                    end
                end
                FILL_RUN: begin
                    if (!cpu_wr_s) begin
                        if (fill_cnt_q == LAST_ADDR) begin
                            state_q     <= FILL_DONE;
                            fill_done_q <= 1'b1;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                FILL_DONE: begin
                    state_q     <= FILL_IDLE;
                    fill_busy_q <= 1'b0;
                    fill_done_q <= 1'b0;
                end
                default: begin
                    state_q     <= FILL_IDLE;
                    fill_busy_q <= 1'b0;
                    fill_done_q <= 1'b0;
                end
            endcase
        end
    end

    nametable_scroll_addr #(
        .NT_WIDTH   (NT_WIDTH),
        .NT_HEIGHT  (NT_HEIGHT),
        .NUM_PAGES  (NUM_PAGES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .XW         (XW),
        .YW         (YW)
    ) u_addr (
        .fetch_x_i   (fetch_x),
        .fetch_y_i   (fetch_y),
        .scroll_x_i  (scroll_x),
        .scroll_y_i  (scroll_y),
        .word_addr_o (word_addr_s),
        .byte_sel_o  (byte_sel_s)
    );

    // Fetch stage 0: capture the wrapped word address and byte lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f0_valid_q <= 1'b0;
            f0_addr_q  <= {ADDR_WIDTH{1'b0}};
            f0_sel_q   <= 2'b00;
        end else begin
            f0_valid_q <= fetch_req;
            f0_addr_q  <= word_addr_s;
            f0_sel_q   <= byte_sel_s;
        end
    end

    // Fetch RAM read with byte select folded in, so the tile leaves a register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_valid_q <= 1'b0;
            fetch_tile_q  <= 8'h00;
        end else begin
            fetch_valid_q <= f0_valid_q;
            fetch_tile_q  <= mem_q[f0_addr_q][{f0_sel_q, 3'b000} +: 8];
        end
    end

    assign cpu_doutb   = cpu_doutb_q;
    assign fill_busy   = fill_busy_q;
    assign fill_done   = fill_done_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_tile  = fetch_tile_q;

endmodule

// File: tb/tb_nametable_scroll_ram.sv
// Scoreboard bench for nametable_scroll_ram: CPU port, fill engine,
// scrolled fetch latency/order, write collision and reset during a fill.
module tb_nametable_scroll_ram;

    localparam int DEPTH = 480;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  cpu_wea = 4'h0;
    logic [8:0]  cpu_addra = 9'd0;
    logic [31:0] cpu_dina = 32'h0;
    logic [8:0]  cpu_addrb = 9'd0;
    logic [31:0] cpu_doutb;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_value = 8'h00;
    logic        fill_busy;
    logic        fill_done;
    logic        fetch_req = 1'b0;
    logic [5:0]  fetch_x = 6'd0;
    logic [4:0]  fetch_y = 5'd0;
    logic [5:0]  scroll_x = 6'd0;
    logic [4:0]  scroll_y = 5'd0;
    logic        fetch_valid;
    logic [7:0]  fetch_tile;

    typedef struct {
        logic [7:0] tile;
        int         due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          sb_en = 1'b1;

    nametable_scroll_ram dut (
        .clk         (clk),
        .rstn        (rstn),
        .cpu_wea     (cpu_wea),
        .cpu_addra   (cpu_addra),
        .cpu_dina    (cpu_dina),
        .cpu_addrb   (cpu_addrb),
        .cpu_doutb   (cpu_doutb),
        .fill_start  (fill_start),
        .fill_value  (fill_value),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
        .fetch_req   (fetch_req),
        .fetch_x     (fetch_x),
        .fetch_y     (fetch_y),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .fetch_valid (fetch_valid),
        .fetch_tile  (fetch_tile)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch results are compared on the falling edge, in order, with exact latency.
    always @(negedge clk) begin
        if (sb_en && rstn && fetch_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("fetch_spurious", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("fetch_tile", {24'h0, fetch_tile}, {24'h0, e.tile});
                check_eq("fetch_latency", cyc, e.due);
            end
        end
    end

    task automatic cpu_write(input int a, input logic [3:0] we, input logic [31:0] d);
        cpu_addra = 9'(a);
        cpu_dina  = d;
        cpu_wea   = we;
        tick();
        cpu_wea = 4'h0;
        for (int b = 0; b < 4; b++)
            if (we[3-b]) model[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic cpu_read_chk(input string tag, input int a);
        cpu_addrb = 9'(a);
        tick();
        check_eq(tag, cpu_doutb, model[a]);
    endtask

    function automatic logic [7:0] exp_tile(input int x, input int y, input int sx, input int sy);
        int ex, ey, t;
        logic [31:0] w;
        ex = (x + sx) % 64;
        ey = (y + sy) % 30;
        t  = (ex / 32) * 960 + ey * 32 + (ex % 32);
        w  = model[t / 4];
        return w[8*(t % 4) +: 8];
    endfunction

    // Drive one request for the coming edge and queue its expected tile.
    task automatic fetch_push(input int x, input int y, input int sx, input int sy);
        exp_t e;
        fetch_x   = 6'(x);
        fetch_y   = 5'(y);
        scroll_x  = 6'(sx);
        scroll_y  = 5'(sy);
        fetch_req = 1'b1;
        e.tile = exp_tile(x, y, sx, sy);
        e.due  = cyc + 2;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        fetch_req = 1'b0;
        repeat (4) tick();
        check_eq("sb_drain", sb_q.size(), 32'd0);
    endtask

    task automatic run_fill(input logic [7:0] v, input int coll_i, input int abort_i,
                            output int done_at, output int busy_cnt, output int done_cnt);
        done_at = 0; busy_cnt = 0; done_cnt = 0;
        fill_value = v;
        fill_start = 1'b1;
        for (int i = 1; i <= 700; i++) begin
            if (i == coll_i) begin
                cpu_addra = 9'd10; cpu_dina = 32'hDEAD_BEEF; cpu_wea = 4'hF;
            end else begin
                cpu_wea = 4'h0;
            end
            if (i == abort_i) begin
                check_eq("pre_reset_valid", {31'h0, fetch_valid}, 32'd1);
                rstn = 1'b0;
                #1;
                check_eq("abort_busy", {31'h0, fill_busy}, 32'd0);
                check_eq("abort_valid", {31'h0, fetch_valid}, 32'd0);
                break;
            end
            tick();
            fill_start = 1'b0;
            if (fill_busy) busy_cnt++;
            if (fill_done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (!fill_busy && i > 1) break;
        end
        cpu_wea = 4'h0;
        fill_start = 1'b0;
    endtask

    initial begin
        int done_at, busy_cnt, done_cnt, seen;

        // Reset state
        repeat (2) tick();
        check_eq("rst_doutb", cpu_doutb, 32'h0);
        check_eq("rst_busy", {31'h0, fill_busy}, 32'd0);
        check_eq("rst_done", {31'h0, fill_done}, 32'd0);
        check_eq("rst_valid", {31'h0, fetch_valid}, 32'd0);
        check_eq("rst_tile", {24'h0, fetch_tile}, 32'd0);
        rstn = 1'b1;
        tick();

        // Random table contents
        for (int w = 0; w < DEPTH; w++) cpu_write(w, 4'hF, $urandom);
        cpu_read_chk("rd_w0", 0);
        cpu_read_chk("rd_w137", 137);
        cpu_read_chk("rd_w479", 479);

        // Reversed byte lanes
        cpu_write(5, 4'hF, 32'h0);
        cpu_write(5, 4'b1000, 32'h0000_00AB);
        cpu_read_chk("lane_w5", 5);
        check_eq("lane_w5_abs", cpu_doutb, 32'h0000_00AB);
        fetch_push(20, 0, 0, 0); tick();
        drain();
        cpu_write(5, 4'b0001, 32'h1100_0000);
        cpu_read_chk("lane_w5_hi", 5);
        fetch_push(23, 0, 0, 0); tick();
        drain();

        // Scroll wrap on both axes
        cpu_write(41, 4'b0010, 32'h005C_0000);
        fetch_push(40, 20, 30, 15); tick();
        drain();
        fetch_push(63, 29, 63, 29); tick();
        fetch_push(0, 0, 31, 0); tick();
        fetch_push(1, 0, 31, 0); tick();
        fetch_push(33, 29, 0, 1); tick();
        drain();

        // Back-to-back throughput, then random in-range traffic
        for (int k = 0; k < 16; k++) begin
            fetch_push(k, 3, 0, 0); tick();
        end
        drain();
        for (int k = 0; k < 24; k++) begin
            fetch_push($urandom_range(63), $urandom_range(29), $urandom_range(63), $urandom_range(29));
            tick();
        end
        drain();

        // Unblocked fill
        run_fill(8'h24, 0, 0, done_at, busy_cnt, done_cnt);
        check_eq("fill_done_cycle", done_at, 32'd481);
        check_eq("fill_busy_cycles", busy_cnt, 32'd481);
        check_eq("fill_done_pulses", done_cnt, 32'd1);
        for (int w = 0; w < DEPTH; w++) model[w] = 32'h2424_2424;
        for (int w = 0; w < DEPTH; w++) cpu_read_chk("fill_word", w);

        // CPU write collides with the fill write to word 10
        run_fill(8'h24, 12, 0, done_at, busy_cnt, done_cnt);
        check_eq("coll_done_cycle", done_at, 32'd482);
        check_eq("coll_busy_cycles", busy_cnt, 32'd482);
        cpu_read_chk("coll_w9", 9);
        cpu_read_chk("coll_w10", 10);
        cpu_read_chk("coll_w11", 11);
        cpu_read_chk("coll_w479", 479);

        // Reset in the middle of a fill, with fetch traffic running
        cpu_write(200, 4'hF, 32'hCAFE_F00D);
        sb_en = 1'b0;
        fetch_x = 6'd0; fetch_y = 5'd0; scroll_x = 6'd0; scroll_y = 5'd0;
        fetch_req = 1'b1;
        run_fill(8'h7E, 0, 101, done_at, busy_cnt, done_cnt);
        fetch_req = 1'b0;
        check_eq("abort_no_done_before", done_cnt, 32'd0);
        repeat (2) tick();
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fill_done || fill_busy) seen++;
        end
        check_eq("abort_no_done_after", seen, 32'd0);
        sb_en = 1'b1;
        for (int w = 0; w < 99; w++) model[w] = 32'h7E7E_7E7E;
        for (int w = 0; w < 99; w++) cpu_read_chk("abort_filled", w);
        cpu_read_chk("abort_w99", 99);
        cpu_read_chk("abort_w200", 200);
        fetch_push(4, 0, 0, 0); tick();
        fetch_push(0, 5, 0, 0); tick();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nametable_scroll_ram.md
Name: nametable_scroll_ram

Overview:
Parametrised, multi-page PPU name table RAM with three users. The Cortex-M0 AHB side gets a byte-write/word-read port. A hardware fill engine clears or fills the whole table. A pipelined scrolled tile-fetch port serves tileDraw, doing the scroll wrap-around in hardware and returning one 8-bit tile index per request.

Parameters:
NT_WIDTH, 32, tiles per row of one page
NT_HEIGHT, 30, tile rows per page
NUM_PAGES, 2, pages placed side by side horizontally (1, 2 or 4)
DEPTH, NUM_PAGES*NT_WIDTH*NT_HEIGHT/4, 32-bit words (480 at defaults)
ADDR_WIDTH, 9, word address width, clog2(DEPTH)
XW, 6, fetch/scroll x width, clog2(NT_WIDTH*NUM_PAGES)
YW, 5, fetch/scroll y width, clog2(NT_HEIGHT)
INIT_FILE, "", optional $readmemh image; empty means no preload

Ports:
clk  in  1  single system clock (CPU and PPU share it)
rstn  in  1  asynchronous active-low reset
cpu_wea  in  4  byte write enables, reversed lanes: wea[3]->[7:0], wea[2]->[15:8], wea[1]->[23:16], wea[0]->[31:24]
cpu_addra  in  ADDR_WIDTH  CPU write word address
cpu_dina  in  32  CPU write data
cpu_addrb  in  ADDR_WIDTH  CPU read word address
cpu_doutb  out  32  CPU read data, registered
fill_start  in  1  pulse: start a fill of the whole table
fill_value  in  8  tile index replicated into every byte
fill_busy  out  1  fill engine active
fill_done  out  1  one-cycle pulse when the fill completes
fetch_req  in  1  tile fetch request, accepted every cycle
fetch_x  in  XW  screen tile column, < NT_WIDTH*NUM_PAGES
fetch_y  in  YW  screen tile row, < NT_HEIGHT
scroll_x  in  XW  horizontal scroll in tiles, < NT_WIDTH*NUM_PAGES
scroll_y  in  YW  vertical scroll in tiles, < NT_HEIGHT
fetch_valid  out  1  fetch_tile valid
fetch_tile  out  8  fetched tile index

Behaviour:
- Reset: cpu_doutb=0, fill_busy=0, fill_done=0, fetch_valid=0, fetch_tile=0, FSM=IDLE, pipeline valids cleared. RAM contents are not reset.
- Tile storage: linear tile index t is stored at word t>>2, bits [8*t[1:0]+7 : 8*t[1:0]].
- CPU read: cpu_doutb <= mem[cpu_addrb] each cycle; latency 1.
- Same-address read/write in one cycle is read-first on every port: old data is returned.
- Write arbitration: a CPU write (any wea bit set) has priority over the fill engine. A fill write in that cycle is held and retried next cycle; the fill address does not advance.
- Fill FSM:
  - IDLE -> FILL on fill_start; load counter=0, latch fill_value.
  - FILL: write {4{value}} to mem[counter] when not blocked; counter+1.
  - FILL -> DONE after writing DEPTH-1.
  - DONE: fill_done=1 for one cycle, then IDLE.
  - fill_busy=1 in FILL and DONE.
  - fill_start while busy is ignored.
  - Unblocked fill takes DEPTH cycles; fill_done asserts in cycle DEPTH+1 after the start cycle.
- Fetch pipeline, latency 2, throughput 1 per cycle, no stall:
  - S0 (request cycle, registered at end):
    - sx = fetch_x+scroll_x; ex = sx - W_TOT if sx >= W_TOT, else sx (W_TOT = NT_WIDTH*NUM_PAGES).
    - sy = fetch_y+scroll_y; ey = sy - NT_HEIGHT if sy >= NT_HEIGHT, else sy.
    - page = ex / NT_WIDTH; col = ex mod NT_WIDTH.
    - t = page*NT_WIDTH*NT_HEIGHT + ey*NT_WIDTH + col.
    - Register word address t>>2, byte select t[1:0], valid.
  - S1: registered RAM read.
  - S2: byte select into fetch_tile; fetch_valid=1.
  - Arithmetic is one conditional subtract, no divider, so the input range limits are mandatory. Out-of-range inputs are undefined.
- Fetches during a fill return old or new bytes per the read-first rule. No interlock.
- Reset mid-fill aborts immediately. The table keeps its partially filled state and fill_done is not pulsed.
- RAM is inferred as block RAM with byte-enable writes and two read ports (CPU and fetch).

Decomposition:
- Shared package/define file: NT_WIDTH, NT_HEIGHT, NUM_PAGES defaults, DEPTH/ADDR_WIDTH derivations, fill FSM state encodings (IDLE/FILL/DONE).
- One natural sub-module: nametable_scroll_addr, the S0 wrap plus linear-index calculation. Reusable by the attribute-table block.

Test Plan:
- Lanes: wea=4'b1000, addra=5, dina=32'h000000AB -> cpu_addrb=5 reads 32'h000000AB one cycle later; a fetch of tile 20 (x=20,y=0, no scroll) returns 8'hAB.
- Scroll wrap: tile 166 = 8'h5C; fetch_x=40, scroll_x=30, fetch_y=20, scroll_y=15 -> word 41, byte 2; fetch_valid plus fetch_tile=8'h5C exactly 2 cycles after fetch_req.
- Fill: fill_start, fill_value=8'h24, no CPU traffic -> fill_done in cycle 481; fill_busy high for 481 cycles; every cpu_doutb reads 32'h24242424.
- Collision: CPU write to addr 10 during fill cycle 10 -> fill stalls one cycle (fill_done in cycle 482); addr 10 ends as 32'h24242424, since the retried fill overwrites the CPU data.
- Reset mid-fill: rstn low at fill cycle 100 -> fill_busy=0 and fetch_valid=0 immediately; words 0..98 are filled, word 200 is unchanged, fill_done is never seen.
- Throughput: 16 back-to-back fetch_req with distinct x -> 16 consecutive fetch_valid cycles, tiles returned in request order.
